// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_sequencer_pkg                                            |
// | Brief    : RV32M funct3 codes and sequencer state encoding.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package muldiv_sequencer_pkg;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'd0,
      MDS_CALC = 2'd1,
      MDS_FIX  = 2'd2,
      MDS_DONE = 2'd3
   } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_cla.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_sequencer_cla                                            |
// | Brief    : N-bit adder/subtractor (generate/propagate carry network).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module muldiv_sequencer_cla #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub_en,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] w_b;
   logic [N-1:0] w_g;
   logic [N-1:0] w_p;
   logic [N:0]   w_c;

   // Subtract is a + ~b + 1; cout=1 then means "no borrow".
   always_comb begin
      w_b    = b ^ {N{sub_en}};
      w_g    = a & w_b;
      w_p    = a ^ w_b;
      w_c    = '0;
      w_c[0] = sub_en;
      for (int i = 0; i < N; i++) begin
         w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
      end
   end

   assign sum  = w_p ^ w_c[N-1:0];
   assign cout = w_c[N];

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_sequencer                                                |
// | Brief    : Iterative RV32M multiply/divide with one shared adder.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reqValid,
   output logic             reqReady,
   input  logic [2:0]       reqOp,
   input  logic [WIDTH-1:0] reqA,
   input  logic [WIDTH-1:0] reqB,
   input  logic             kill,
   output logic             respValid,
   input  logic             respReady,
   output logic [WIDTH-1:0] respResult,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   md_state_e        r_state, w_next_state;
   logic             r_resp_valid;
   logic [CNT_W-1:0] r_count;
   logic [2:0]       r_op;
   logic             r_neg_res;
   logic [WIDTH-1:0] r_opnd;     // multiplicand or divisor magnitude
   logic [WIDTH-1:0] r_hi;       // product high half or remainder
   logic [WIDTH-1:0] r_lo;       // multiplier/product low half or quotient
   logic [WIDTH-1:0] r_result;

   logic             w_accept, w_abs_a, w_abs_b, w_neg_res;
   logic             w_div_zero, w_ovf, w_special;
   logic [WIDTH-1:0] w_opa, w_opb, w_special_res;
   logic [WIDTH:0]   w_add_a, w_add_b, w_sum;
   logic             w_sub, w_cout, w_fix_inc;
   logic [WIDTH-1:0] w_fix_src, w_fix_res;

   assign w_accept = reqValid & (r_state == MDS_IDLE) & ~kill;

   // Operand conditioning: which operands are taken as magnitudes, and
   // whether the final result needs a sign correction.
   always_comb begin
      w_abs_a   = 1'b0;
      w_abs_b   = 1'b0;
      w_neg_res = 1'b0;
      case (reqOp)
         MD_MULH, MD_DIV: begin
            w_abs_a   = 1'b1;
            w_abs_b   = 1'b1;
            w_neg_res = reqA[WIDTH-1] ^ reqB[WIDTH-1];
         end
         MD_MULHSU: begin
            w_abs_a   = 1'b1;
            w_neg_res = reqA[WIDTH-1];
         end
         MD_REM: begin
            w_abs_a   = 1'b1;
            w_abs_b   = 1'b1;
            w_neg_res = reqA[WIDTH-1];
         end
         default: ;
      endcase
   end

   assign w_opa = (w_abs_a & reqA[WIDTH-1]) ? -reqA : reqA;
   assign w_opb = (w_abs_b & reqB[WIDTH-1]) ? -reqB : reqB;

   assign w_div_zero    = reqOp[2] & (reqB == '0);
   assign w_ovf         = reqOp[2] & ~reqOp[0] & (reqA == {1'b1, {(WIDTH-1){1'b0}}}) & (&reqB);
   assign w_special     = w_div_zero | w_ovf;
   assign w_special_res = w_div_zero ? (reqOp[1] ? reqA : '1)
                                     : (reqOp[1] ? '0   : reqA);

   // FIX negation of the 2W product uses -{hi,lo} = {~hi + (lo==0), ~lo + 1}.
   always_comb begin
      w_fix_src = r_lo;
      w_fix_inc = 1'b1;
      if (r_op[2]) begin
         w_fix_src = r_op[1] ? r_hi : r_lo;
      end else if (r_op != MD_MUL) begin
         w_fix_src = r_hi;
         w_fix_inc = (r_lo == '0);
      end
   end

   always_comb begin
      w_add_a = '0;
      w_add_b = '0;
      w_sub   = 1'b0;
      case (r_state)
         MDS_CALC: begin
            if (r_op[2]) begin
               w_add_a = {r_hi, r_lo[WIDTH-1]};
               w_add_b = {1'b0, r_opnd};
               w_sub   = 1'b1;
            end else begin
               w_add_a = {1'b0, r_hi};
               w_add_b = r_lo[0] ? {1'b0, r_opnd} : '0;
            end
         end
         MDS_FIX: begin
            w_add_a = {1'b0, ~w_fix_src};
            w_add_b = {{WIDTH{1'b0}}, w_fix_inc};
         end
         default: ;
      endcase
   end

   muldiv_sequencer_cla #(.N(WIDTH + 1)) u_cla (
      .a      (w_add_a),
      .b      (w_add_b),
      .sub_en (w_sub),
      .sum    (w_sum),
      .cout   (w_cout)
   );

   assign w_fix_res = r_neg_res ? w_sum[WIDTH-1:0] : w_fix_src;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MDS_IDLE: if (w_accept) w_next_state = w_special ? MDS_DONE : MDS_CALC;
         MDS_CALC: if (r_count == CNT_LAST) w_next_state = MDS_FIX;
         MDS_FIX:  w_next_state = MDS_DONE;
         MDS_DONE: if (respReady) w_next_state = MDS_IDLE;
         default:  w_next_state = MDS_IDLE;
      endcase
      if (kill) w_next_state = MDS_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= MDS_IDLE;
         r_resp_valid <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_resp_valid <= (w_next_state == MDS_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_op      <= '0;
         r_neg_res <= 1'b0;
         r_opnd    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_result  <= '0;
      end else if (!kill) begin
         case (r_state)
            MDS_IDLE: begin
               if (w_accept) begin
                  r_count   <= '0;
                  r_op      <= reqOp;
                  r_neg_res <= w_neg_res;
                  r_opnd    <= reqOp[2] ? w_opb : w_opa;
                  r_lo      <= reqOp[2] ? w_opa : w_opb;
                  r_hi      <= '0;
                  if (w_special) r_result <= w_special_res;
               end
            end
            MDS_CALC: begin
               r_count <= r_count + 1'b1;
               if (r_op[2]) begin
                  r_hi <= w_cout ? w_sum[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                  r_lo <= {r_lo[WIDTH-2:0], w_cout};
               end else begin
                  r_hi <= w_sum[WIDTH:1];
                  r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
               end
            end
            MDS_FIX:  r_result <= w_fix_res;
            default: ;
         endcase
      end
   end

   assign reqReady   = rst_n & (r_state == MDS_IDLE);
   assign busy       = (r_state != MDS_IDLE);
   assign respValid  = r_resp_valid;
   assign respResult = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_sequencer                                             |
// | Brief    : Randomised self-checking bench against an arithmetic model.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_muldiv_sequencer;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          reqValid = 1'b0;
   logic          reqReady;
   logic [2:0]    reqOp = 3'd0;
   logic [W-1:0]  reqA = '0;
   logic [W-1:0]  reqB = '0;
   logic          kill = 1'b0;
   logic          respValid;
   logic          respReady = 1'b0;
   logic [W-1:0]  respResult;
   logic          busy;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqOp      (reqOp),
      .reqA       (reqA),
      .reqB       (reqB),
      .kill       (kill),
      .respValid  (respValid),
      .respReady  (respReady),
      .respResult (respResult),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   // Expectation table: written by the driver, consumed by the checker.
   logic [W-1:0] exp_res [0:511];
   int           exp_acc [0:511];
   int           exp_lat [0:511];
   int           wr_id    = 0;
   int           flush_to = 0;
   int           rd_id    = 0;
   bit           seen     = 1'b0;
   int           rr_mode  = 0;   // 0 random, 1 force low, 2 force high

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      int          ia, ib;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ia  = a;
      ib  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 1;
      return W + 2;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Consumer-side ready generator.
   initial forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
         1: respReady = 1'b0;
         2: respReady = 1'b1;
         default: respReady = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Compare process: every cycle a response is pending or presented.
   initial forever begin
      @(negedge clk);
      if (rd_id < flush_to) begin
         rd_id = flush_to;
         seen  = 1'b0;
      end
      if (rst_n) begin
         if (respValid) begin
            if (rd_id >= wr_id) begin
               chk("spurious respValid", {31'd0, respValid}, 32'd0);
            end else begin
               chk("result", respResult, exp_res[rd_id]);
               chk("reqReady in DONE", {31'd0, reqReady}, 32'd0);
               chk("busy in DONE", {31'd0, busy}, 32'd1);
               if (!seen) chk("latency", 32'(cyc - exp_acc[rd_id]), 32'(exp_lat[rd_id]));
               seen = 1'b1;
               if (respReady) begin
                  rd_id++;
                  seen = 1'b0;
               end
            end
         end else if (rd_id < wr_id && !seen && (cyc - exp_acc[rd_id]) == exp_lat[rd_id]) begin
            chk("respValid on time", {31'd0, respValid}, 32'd1);
         end
      end
   end

   // Caller is at a negedge; accepted on the following posedge.
   task automatic do_req(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < 300 && !reqReady; i++) @(negedge clk);
      if (!reqReady) chk("reqReady wait", {31'd0, reqReady}, 32'd1);
      reqValid = 1'b1;
      reqOp    = op;
      reqA     = a;
      reqB     = b;
      exp_res[wr_id] = model(op, a, b);
      exp_acc[wr_id] = cyc;
      exp_lat[wr_id] = latency(op, a, b);
      wr_id++;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 300 && rd_id < wr_id; i++) @(negedge clk);
      if (rd_id < wr_id) begin
         chk("response timeout", 32'(rd_id), 32'(wr_id));
         flush_to = wr_id;
         @(negedge clk);
      end
   endtask

   initial begin
      // Model sanity against hand-computed values.
      chk("model MUL",    model(3'd0, 32'd7, 32'hFFFF_FFFD),          32'hFFFF_FFEB);
      chk("model MULH",   model(3'd1, 32'h8000_0000, 32'h8000_0000),  32'h4000_0000);
      chk("model MULHU",  model(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFE);
      chk("model MULHSU", model(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF),  32'hFFFF_FFFF);
      chk("model DIV",    model(3'd4, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFD);
      chk("model REM",    model(3'd6, 32'hFFFF_FFF9, 32'd2),          32'hFFFF_FFFF);
      chk("model DIVU",   model(3'd5, 32'd100, 32'd7),                32'd14);
      chk("model REMU",   model(3'd7, 32'd100, 32'd7),                32'd2);
      chk("model DIV/0",  model(3'd4, 32'd5, 32'd0),                  32'hFFFF_FFFF);
      chk("model REM/0",  model(3'd6, 32'd5, 32'd0),                  32'd5);
      chk("model DIVovf", model(3'd4, 32'h8000_0000, 32'hFFFF_FFFF),  32'h8000_0000);
      chk("model REMovf", model(3'd6, 32'h8000_0000, 32'hFFFF_FFFF),  32'd0);

      #2;
      chk("rst reqReady",   {31'd0, reqReady},  32'd0);
      chk("rst respValid",  {31'd0, respValid}, 32'd0);
      chk("rst respResult", respResult,         32'd0);
      chk("rst busy",       {31'd0, busy},      32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post-rst reqReady", {31'd0, reqReady}, 32'd1);

      // Directed cases.
      do_req(3'd0, 32'd7, 32'hFFFF_FFFD);          wait_done();
      do_req(3'd1, 32'h8000_0000, 32'h8000_0000);  wait_done();
      do_req(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done();
      do_req(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);  wait_done();
      do_req(3'd4, 32'hFFFF_FFF9, 32'd2);          wait_done();
      do_req(3'd6, 32'hFFFF_FFF9, 32'd2);          wait_done();
      do_req(3'd5, 32'd100, 32'd7);                wait_done();
      do_req(3'd7, 32'd100, 32'd7);                wait_done();
      do_req(3'd4, 32'd5, 32'd0);                  wait_done();
      do_req(3'd6, 32'd5, 32'd0);                  wait_done();
      do_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();
      do_req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();

      // Backpressure: hold DONE for 10 cycles, then a back-to-back request.
      rr_mode = 1;
      do_req(3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
      for (int i = 0; i < 100 && !respValid; i++) @(negedge clk);
      if (!respValid) chk("bp respValid", {31'd0, respValid}, 32'd1);
      repeat (10) @(negedge clk);
      rr_mode = 2;
      wait_done();
      @(posedge clk);
      #1;
      rr_mode = 1;
      respReady = respReady;
      @(negedge clk);
      chk("retire reqReady", {31'd0, reqReady}, 32'd1);
      chk("retire busy",     {31'd0, busy},     32'd0);
      do_req(3'd0, 32'd11, 32'd13);
      @(negedge clk);
      chk("b2b accepted", {31'd0, busy}, 32'd1);
      rr_mode = 0;
      wait_done();

      // Kill during CALC cycle 10.
      do_req(3'd0, 32'($urandom), 32'($urandom));
      repeat (10) @(posedge clk);
      #1;
      kill = 1'b1;
      flush_to = wr_id;
      @(posedge clk);
      #1;
      kill = 1'b0;
      @(negedge clk);
      chk("kill busy",      {31'd0, busy},      32'd0);
      chk("kill reqReady",  {31'd0, reqReady},  32'd1);
      chk("kill respValid", {31'd0, respValid}, 32'd0);
      repeat (40) @(negedge clk);
      do_req(3'd0, 32'd3, 32'd4);
      wait_done();

      // Kill in IDLE blocks the request.
      reqValid = 1'b1;
      reqOp    = 3'd0;
      kill     = 1'b1;
      @(posedge clk);
      #1;
      reqValid = 1'b0;
      kill     = 1'b0;
      @(negedge clk);
      chk("kill-idle busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset during CALC cycle 20.
      do_req(3'd1, 32'($urandom), 32'($urandom));
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      flush_to = wr_id;
      #1;
      chk("arst reqReady",   {31'd0, reqReady},  32'd0);
      chk("arst respValid",  {31'd0, respValid}, 32'd0);
      chk("arst respResult", respResult,         32'd0);
      chk("arst busy",       {31'd0, busy},      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("arst idle reqReady", {31'd0, reqReady}, 32'd1);

      // Randomised traffic.
      for (int t = 0; t < 150; t++) begin
         do_req(3'($urandom_range(0, 7)), pick(), pick());
         wait_done();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative RV32M multiply/divide unit beside the execute-stage ALU. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU operation per request and runs a radix-2 shift-add or restoring-divide loop. The loop uses a single shared WIDTH+1-bit adder/subtractor. A valid/ready handshake on each side lets the pipeline stall on `reqReady`/`respValid`, and `kill` lets a flush abandon an in-flight operation.

## Interface
- `WIDTH`, 32: operand/result width; even, ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  unit can accept a request (state IDLE).
- `reqOp`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `reqA`  in  WIDTH  rs1 operand (multiplicand / dividend).
- `reqB`  in  WIDTH  rs2 operand (multiplier / divisor).
- `kill`  in  1  synchronous abort; dominates every other input except reset.
- `respValid`  out  1  result available.
- `respReady`  in  1  consumer takes result.
- `respResult`  out  WIDTH  result, registered.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `reqReady`=1.
  - On accept (`reqValid`&`reqReady`&!`kill`), latch the op, the operand signs, and the absolute values.
  - MUL takes absolute values of neither operand. MULH takes both. MULHSU takes `reqA` only. Unsigned ops take neither. DIV/REM take both.
  - Counter is cleared on accept; next state is CALC, except for the special cases below.
- Special cases go IDLE→DONE directly, with `respResult` loaded on the accept edge:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → `reqA`.
  - Signed overflow, DIV/REM with `reqA`=100…0 and `reqB`=all ones: DIV → `reqA`; REM → 0.
- CALC: exactly WIDTH cycles, counter 0…WIDTH-1.
  - Multiply: if multiplier LSB=1, {acc_hi} += multiplicand using the WIDTH+1 adder; then shift {carry, acc_hi, acc_lo} right by 1.
  - Divide (restoring): shift {rem, quot} left by 1; trial = rem − divisor (WIDTH+1 subtract). If there is no borrow, rem = trial and quot LSB = 1; otherwise quot LSB = 0.
- FIX: 1 cycle; loads `respResult`.
  - Multiply: negate the 2·WIDTH product if the latched signs differ (signed ops only). Select the low half for MUL, the high half otherwise.
  - Divide: negate the quotient if the operand signs differ (DIV). Negate the remainder if the dividend is negative (REM).
  - Next state is DONE.
- DONE: `respValid`=1; `respResult` is held stable until `respReady`. On handshake, go to IDLE.
- `kill` in any state: next state IDLE, `respValid`=0 next cycle, result discarded. `kill` in IDLE with `reqValid` → request not accepted.
- All arithmetic is modulo 2^WIDTH (or 2^2·WIDTH for the product); negate = invert+1 through the same adder path.

## Timing
- Reset: state IDLE, counter 0, all datapath registers 0, `reqReady`=1 after reset release (0 while `rst_n`=0), `respValid`=0, `respResult`=0, `busy`=0.
- Normal latency: accept at cycle 0 → CALC cycles 1…WIDTH → FIX cycle WIDTH+1 → `respValid` first high in cycle WIDTH+2 (34 for WIDTH=32).
- Special-case latency: `respValid` high in cycle 1.
- `respValid`&`respReady` in cycle N → `reqReady`=1 in cycle N+1. No same-cycle accept-on-retire; peak throughput is 1 op / WIDTH+3 cycles.
- `reqReady` is a function of state only (no combinational path from `reqValid`). `respValid` and `respResult` come straight from registers.
- `rst_n` falling mid-operation: all outputs take their reset values immediately, asynchronously; no response is produced afterwards.

## Structure
- Shared package/header (`types.vh`):
  - `MD_MUL`…`MD_REMU` funct3 constants.
  - State encodings `MDS_IDLE`/`MDS_CALC`/`MDS_FIX`/`MDS_DONE`.
- One adder instance: the existing `CLA` at WIDTH+1, with `subEn` driven by op class and state. Multiply adds, divide subtracts, and FIX negation reuses the same instance. No second adder.
- No further sub-module. The FSM, counter, and shift registers stay in `muldiv_sequencer`.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `respResult`=0xFFFFFFEB; `respValid` first high exactly 34 cycles after accept.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, both with `respValid` in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
- Backpressure: hold `respReady`=0 for 10 cycles in DONE → `respResult` stable, `reqReady`=0, `busy`=1. Release → IDLE next cycle; a back-to-back request is accepted in the following cycle.
- Abort/reset: `kill` at CALC cycle 10 → IDLE next cycle with no `respValid`, and a subsequent MUL 3×4 returns 12. `rst_n` low at CALC cycle 20 → all outputs at reset values immediately.
